// File: rtl/riscv_mem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
// Lane numbering is little-endian: byte lane n sits in bits [8n+7:8n].
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misalignment or a funct3 that is not legal for the direction.
    function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] lane);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = lane[0];
            F3_W:    err = (lane != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | lane[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [2:0] funct3,
                                                 input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'd0, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'd0, h};
            F3_W:    res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] lane);
        logic [3:0] be;
        case (funct3)
            F3_B:    be = 4'b0001 << lane;
            F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate narrow store data so every lane carries it; byte enables pick the lane.
    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] d;
        case (funct3)
            F3_B:    d = {4{wdata[7:0]}};
            F3_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Contents are deliberately left unreset.
module mem_word_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH];

    // Byte-masked write and registered read on the same enabled edge.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem_r[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with programmable latency in front of
// on-chip word storage; the storage access happens on the edge that enters RESP.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic       LAT_ZERO = (LATENCY == 32'sd0);
    localparam logic [3:0] LAT_LOAD = LAT_ZERO ? 4'd0 : 4'(LATENCY - 32'sd1);

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [2:0]        f3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic              err_r;

    logic              src_we_s;
    logic [2:0]        src_f3_s;
    logic [ADDR_W-1:0] src_addr_s;
    logic [31:0]       src_wdata_s;
    logic              access_s;
    logic              err_s;
    logic              mem_en_s;
    logic [3:0]        mem_be_s;
    logic [IDX_W-1:0]  mem_idx_s;
    logic [31:0]       mem_wdata_s;
    logic [31:0]       ram_q_s;
    logic [31:0]       rdata_s;

    // With zero latency the access happens on the accept edge, so it must use the live request.
    always_comb begin
        if (state_r == IDLE) begin
            src_we_s    = req_we;
            src_f3_s    = req_funct3;
            src_addr_s  = req_addr;
            src_wdata_s = req_wdata;
        end else begin
            src_we_s    = we_r;
            src_f3_s    = f3_r;
            src_addr_s  = addr_r;
            src_wdata_s = wdata_r;
        end
    end

    // Storage access strobe, error classification and store lane steering.
    always_comb begin
        case (state_r)
            IDLE:    access_s = req_valid & LAT_ZERO;
            WAIT:    access_s = (cnt_r == 4'd0);
            default: access_s = 1'b0;
        endcase
        err_s       = access_err(src_we_s, src_f3_s, src_addr_s[1:0]);
        mem_en_s    = access_s & ~reset;
        mem_idx_s   = IDX_W'(src_addr_s >> 2'd2);
        mem_wdata_s = store_data(src_f3_s, src_wdata_s);
        if (mem_en_s && src_we_s && !err_s) begin
            mem_be_s = store_be(src_f3_s, src_addr_s[1:0]);
        end else begin
            mem_be_s = 4'b0000;
        end
    end

    mem_word_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (mem_en_s),
        .be    (mem_be_s),
        .idx   (mem_idx_s),
        .wdata (mem_wdata_s),
        .rdata (ram_q_s)
    );

    // Request/response handshake FSM with the latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            f3_r        <= 3'd0;
            addr_r      <= '0;
            wdata_r     <= 32'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r        <= req_we;
                        f3_r        <= req_funct3;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        req_ready_r <= 1'b0;
                        if (LAT_ZERO) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            err_r       <= err_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= LAT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        err_r       <= err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        err_r       <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= 4'd0;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    err_r       <= 1'b0;
                end
            endcase
        end
    end

    // The array output only moves on the commit edge, so this decode is stable throughout RESP.
    always_comb begin
        if (rsp_valid_r && !err_r && !we_r) begin
            rdata_s = lane_extract(ram_q_s, f3_r, addr_r[1:0]);
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = err_r;
    assign rsp_rdata = rdata_s;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, multi-cycle corner sequences,
// and random traffic against a byte-level reference memory.
module tb_data_mem_responder;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset, sel, req_valid, req_we, rsp_ready;
    logic [2:0]  req_funct3;
    logic [12:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready0, rsp_valid0, rsp_err0, req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata0, rsp_rdata1;
    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [31:0] rsp_rdata_m;
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  mb [2][4096];

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(32), .ADDR_W(12), .DEPTH(1024), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(req_ready0),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr[11:0]),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0));

    data_mem_responder #(.DATA_W(32), .ADDR_W(13), .DEPTH(1024), .LATENCY(0)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(req_ready1),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1));

    assign req_ready_m = sel ? req_ready1 : req_ready0;
    assign rsp_valid_m = sel ? rsp_valid1 : rsp_valid0;
    assign rsp_err_m   = sel ? rsp_err1   : rsp_err0;
    assign rsp_rdata_m = sel ? rsp_rdata1 : rsp_rdata0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [12:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, size = 2^funct3[1:0] bytes, little-endian.
    task automatic model(input bit s, input logic we, input logic [2:0] f3, input logic [12:0] addr,
                         input logic [31:0] wd, output logic [31:0] exp_rd, output logic exp_err);
        int     size, a;
        longint v;
        bit     legal;
        size    = 1 << f3[1:0];
        a       = int'(addr) % 4096;
        legal   = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        exp_err = !legal || (a % size != 0);
        exp_rd  = 32'd0;
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mb[s][a+i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v = v + (longint'(mb[s][a+i]) << (8*i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8*size));
                exp_rd = v[31:0];
            end
        end
    endtask

    task automatic txn(input bit s, input logic we, input logic [2:0] f3, input logic [12:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int n;
        sel = s;
        n = 0;
        while (req_ready_m !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready_m !== 1'b1) check("req_ready timeout", {31'd0, req_ready_m}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid_m === 1'b1) break;
        end
        if (rsp_valid_m !== 1'b1) check("rsp_valid timeout", {31'd0, rsp_valid_m}, 32'd1);
        rd = rsp_rdata_m;
        er = rsp_err_m;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_chk(input bit s, input logic we, input logic [2:0] f3, input logic [12:0] addr,
                          input logic [31:0] wd, input int exp_lat, input string tag);
        logic [31:0] erd, rd;
        logic        eer, er;
        int          lat;
        model(s, we, f3, addr, wd, erd, eer);
        txn(s, we, f3, addr, wd, rd, er, lat);
        check({tag, " rdata"}, rd, erd);
        check({tag, " err"}, {31'd0, er}, {31'd0, eer});
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, {31'd0, req_ready_m}, 32'd1);
        check({tag, " rsp_valid"}, {31'd0, rsp_valid_m}, 32'd0);
        check({tag, " rsp_err"},   {31'd0, rsp_err_m},   32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata_m, 32'd0);
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid_m !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " reach RESP"}, {31'd0, rsp_valid_m}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [16];
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat;

        vecs[0]  = '{1'b1, F3_W,   13'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, F3_W,   13'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, F3_B,   13'h013, 32'h00000080, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, F3_B,   13'h013, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b0, F3_BU,  13'h013, 32'h0,        32'h00000080, 1'b0};
        vecs[5]  = '{1'b0, F3_W,   13'h010, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[6]  = '{1'b0, F3_H,   13'h011, 32'h0,        32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, F3_W,   13'h012, 32'h12345678, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b0, F3_W,   13'h010, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[9]  = '{1'b0, F3_H,   13'h012, 32'h0,        32'hFFFF80AD, 1'b0};
        vecs[10] = '{1'b0, F3_HU,  13'h012, 32'h0,        32'h000080AD, 1'b0};
        vecs[11] = '{1'b1, F3_H,   13'h010, 32'hABCD7FFF, 32'h00000000, 1'b0};
        vecs[12] = '{1'b0, F3_W,   13'h010, 32'h0,        32'h80AD7FFF, 1'b0};
        vecs[13] = '{1'b0, 3'b011, 13'h010, 32'h0,        32'h00000000, 1'b1};
        vecs[14] = '{1'b1, F3_BU,  13'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[15] = '{1'b0, F3_W,   13'h010, 32'h0,        32'h80AD7FFF, 1'b0};

        reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
        req_funct3 = 3'd0; req_addr = 13'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        for (int i = 0; i < 16; i++) begin
            model(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, erd, eer);
            txn(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, er, lat);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].rd);
            check($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vecs[i].err});
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
        end

        // Stall in RESP: outputs hold, new requests are ignored.
        sel = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 13'h010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        wait_rsp("stall");
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 13'h010; req_wdata = 32'h55555555;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d rsp_valid", k), {31'd0, rsp_valid_m}, 32'd1);
            check($sformatf("stall%0d rdata", k), rsp_rdata_m, 32'h80AD7FFF);
            check($sformatf("stall%0d req_ready", k), {31'd0, req_ready_m}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("post-stall req_ready", {31'd0, req_ready_m}, 32'd1);
        check("post-stall rsp_valid", {31'd0, rsp_valid_m}, 32'd0);
        txn(1'b0, 1'b0, F3_W, 13'h010, 32'd0, rd, er, lat);
        check("ignored store", rd, 32'h80AD7FFF);

        // Reset in WAIT discards the store; reset in RESP keeps it.
        do_chk(1'b0, 1'b1, F3_W, 13'h020, 32'h11111111, 3, "pre");
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 13'h020; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst-wait");
        txn(1'b0, 1'b0, F3_W, 13'h020, 32'd0, rd, er, lat);
        check("rst-wait discard", rd, 32'h11111111);

        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 13'h020; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        wait_rsp("rst-resp");
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst-resp");
        model(1'b0, 1'b1, F3_W, 13'h020, 32'h12345678, erd, eer);
        txn(1'b0, 1'b0, F3_W, 13'h020, 32'd0, rd, er, lat);
        check("rst-resp persist", rd, 32'h12345678);

        // Zero-latency instance with 13-bit addresses wrapping onto 1024 words.
        do_chk(1'b1, 1'b1, F3_W, 13'h0004, 32'hCAFEF00D, 1, "lat0 sw");
        do_chk(1'b1, 1'b0, F3_W, 13'h0004, 32'd0, 1, "lat0 lw");
        txn(1'b1, 1'b0, F3_W, 13'h1004, 32'd0, rd, er, lat);
        check("wrap rdata", rd, 32'hCAFEF00D);
        check("wrap latency", 32'(lat), 32'd1);

        // Random traffic over a pre-initialised window.
        for (int w = 0; w < 16; w++) begin
            do_chk(1'b0, 1'b1, F3_W, 13'h100 + 13'(4*w), $urandom, 3, $sformatf("init%0d", w));
        end
        for (int r = 0; r < 80; r++) begin
            do_chk(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   13'h100 + 13'($urandom_range(0, 63)), $urandom, 3, $sformatf("rnd%0d", r));
        end
        for (int r = 0; r < 20; r++) begin
            do_chk(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   13'h0004 + 13'($urandom_range(0, 3)) + (13'($urandom_range(0, 1)) << 12),
                   $urandom, 1, $sformatf("rnd1_%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
